// File: rtl/fpm_norm_round_if.sv
// fpm_norm_round handshake bundle.
// Holds the upstream beat, the downstream result and the two valid/ready pairs.
interface fpm_norm_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [63:0] in_product;
  logic        in_nan;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_product,
    output in_nan, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_product,
    input  in_nan, in_inf, in_zero, out_ready,
    output in_ready, out_valid, out_result,
    output out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fpm_norm_round.sv
// FPM normalize (stage 1) and RNE round/pack (stage 2).
// Two-beat pipeline with valid/ready on both sides.
module fpm_norm_round (
  input  logic               clk,
  input  logic               rst_n,
  fpm_norm_round_if.slave    bus
);

  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              inf;
    logic              zero;
    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic signed [9:0] exp;
  } s1_t;

  s1_t         s1;
  s1_t         s1_nxt;
  logic        s1_valid;
  logic        s2_load;
  logic        in_ready;

  logic        out_valid;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_udf;
  logic        out_inx;

  logic        rnd;
  logic [23:0] m_sum;
  logic signed [9:0] e_rnd;
  logic [31:0] res_nxt;
  logic        ovf_nxt;
  logic        udf_nxt;
  logic        inx_nxt;

  logic        unused_hi;
  assign unused_hi = ^bus.in_product[63:48];

  assign s2_load  = !out_valid | bus.out_ready;
  assign in_ready = !s1_valid | s2_load;

  always_comb begin
    s1_nxt      = '0;
    s1_nxt.sign = bus.in_sign;
    s1_nxt.nan  = bus.in_nan;
    s1_nxt.inf  = bus.in_inf;
    s1_nxt.zero = bus.in_zero;
    if (bus.in_product[47]) begin
      s1_nxt.mant   = bus.in_product[46:24];
      s1_nxt.guard  = bus.in_product[23];
      s1_nxt.sticky = |bus.in_product[22:0];
      s1_nxt.exp    = bus.in_exp + 10'sd1;
    end else begin
      s1_nxt.mant   = bus.in_product[45:23];
      s1_nxt.guard  = bus.in_product[22];
      s1_nxt.sticky = |bus.in_product[21:0];
      s1_nxt.exp    = bus.in_exp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1 <= s1_nxt;
    end
  end

  // Rounding carry leaves m_sum[22:0] zero, so no explicit clear is needed.
  always_comb begin
    rnd     = s1.guard & (s1.sticky | s1.mant[0]);
    m_sum   = {1'b0, s1.mant} + {23'd0, rnd};
    e_rnd   = s1.exp + $signed({9'd0, m_sum[23]});
    res_nxt = {s1.sign, e_rnd[7:0], m_sum[22:0]};
    ovf_nxt = 1'b0;
    udf_nxt = 1'b0;
    inx_nxt = s1.guard | s1.sticky;
    if (s1.nan) begin
      res_nxt = 32'h7FC0_0000;
      inx_nxt = 1'b0;
    end else if (s1.inf) begin
      res_nxt = {s1.sign, 8'hFF, 23'd0};
      inx_nxt = 1'b0;
    end else if (s1.zero) begin
      res_nxt = {s1.sign, 31'd0};
      inx_nxt = 1'b0;
    end else if (e_rnd >= 10'sd255) begin
      res_nxt = {s1.sign, 8'hFF, 23'd0};
      ovf_nxt = 1'b1;
      inx_nxt = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      res_nxt = {s1.sign, 31'd0};
      udf_nxt = 1'b1;
      inx_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_udf    <= 1'b0;
      out_inx    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_nxt;
        out_ovf    <= ovf_nxt;
        out_udf    <= udf_nxt;
        out_inx    <= inx_nxt;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_result    = out_result;
  assign bus.out_overflow  = out_ovf;
  assign bus.out_underflow = out_udf;
  assign bus.out_inexact   = out_inx;

endmodule

// File: tb/tb_fpm_norm_round.sv
// Directed bench for fpm_norm_round.
// Expected results are hand-derived binary32 words queued per accepted beat.
module tb_fpm_norm_round;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpm_norm_round_if bus ();

  fpm_norm_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [34:0] sbq[$];
  string       tq[$];
  logic [34:0] pend;
  string       ptag;
  logic        acc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic s,
                       input logic [9:0] e, input logic [63:0] p,
                       input logic [2:0] spc, input logic [31:0] r,
                       input logic [2:0] f);
    bus.in_valid   = 1'b1;
    bus.in_sign    = s;
    bus.in_exp     = e;
    bus.in_product = p;
    bus.in_nan     = spc[2];
    bus.in_inf     = spc[1];
    bus.in_zero    = spc[0];
    pend           = {f, r};
    ptag           = tag;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_nan   = 1'b0;
    bus.in_inf   = 1'b0;
    bus.in_zero  = 1'b0;
  endtask

  // One cycle: look at both handshakes just before the edge.
  task automatic step();
    logic [34:0] got;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      got = {bus.out_overflow, bus.out_underflow,
             bus.out_inexact, bus.out_result};
      if (sbq.size() == 0) chk("extra_out", 1, 0);
      else chk(tq.pop_front(), got, sbq.pop_front());
    end
    if (acc) begin
      sbq.push_back(pend);
      tq.push_back(ptag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    idle();
    for (int i = 0; i < 10 && sbq.size() != 0; i++) step();
    chk(tag, sbq.size(), 0);
  endtask

  task automatic send(input string tag, input logic s,
                      input logic [9:0] e, input logic [63:0] p,
                      input logic [2:0] spc, input logic [31:0] r,
                      input logic [2:0] f);
    drive(tag, s, e, p, spc, r, f);
    step();
    chk({"acc_", tag}, acc, 1);
  endtask

  int          idx;
  int          seen;
  logic [31:0] held;

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_product = '0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_flags", {bus.out_overflow, bus.out_underflow,
                      bus.out_inexact}, 0);
    chk("rst_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    bus.out_ready = 1'b1;
    drive("one", 0, 10'd127, 64'h4000_0000_0000, 0, 32'h3F80_0000, 0);
    step();
    idle();
    chk("lat_k", bus.out_valid, 0);
    step();
    chk("lat_k1", bus.out_valid, 1);
    drain("drain_lat");

    send("onehalf", 0, 10'd127, 64'h9000_0000_0000, 0, 32'h4010_0000, 0);
    send("hi_ign", 0, 10'd127, 64'hABCD_4000_0000_0000, 0,
         32'h3F80_0000, 0);
    send("tie_even", 0, 10'd127, 64'h4000_0040_0000, 0,
         32'h3F80_0000, 3'b001);
    send("tie_odd", 0, 10'd127, 64'h4000_00C0_0000, 0,
         32'h3F80_0002, 3'b001);
    send("sticky_up", 0, 10'd127, 64'h4000_0060_0000, 0,
         32'h3F80_0001, 3'b001);
    send("carry", 0, 10'd127, 64'h7FFF_FFC0_0000, 0,
         32'h4000_0000, 3'b001);
    send("all_ones", 0, 10'd127, 64'h7FFF_FF80_0000, 0,
         32'h3FFF_FFFF, 0);
    send("ovf", 0, 10'd254, 64'h8000_0000_0000, 0,
         32'h7F80_0000, 3'b101);
    send("ovf_neg", 1, 10'd254, 64'h8000_0000_0000, 0,
         32'hFF80_0000, 3'b101);
    send("max_exp", 0, 10'd254, 64'h4000_0000_0000, 0,
         32'h7F00_0000, 0);
    send("ovf_rnd", 0, 10'd254, 64'h7FFF_FFC0_0000, 0,
         32'h7F80_0000, 3'b101);
    send("udf", 0, 10'd0, 64'h4000_0000_0000, 0,
         32'h0000_0000, 3'b011);
    send("udf_neg", 1, 10'd0, 64'h4000_0000_0000, 0,
         32'h8000_0000, 3'b011);
    send("min_exp", 0, 10'd1, 64'h4000_0000_0000, 0,
         32'h0080_0000, 0);
    send("udf_negexp", 0, 10'h3FB, 64'h8000_0000_0000, 0,
         32'h0000_0000, 3'b011);
    send("nan", 0, 10'd127, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100,
         32'h7FC0_0000, 0);
    send("inf_neg", 1, 10'd254, 64'h8000_0000_0000, 3'b010,
         32'hFF80_0000, 0);
    send("zero", 0, 10'd0, 64'h4000_0000_0000, 3'b001,
         32'h0000_0000, 0);
    send("zero_neg", 1, 10'd127, 64'h7FFF_FFC0_0000, 3'b001,
         32'h8000_0000, 0);
    drain("drain_stream");

    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      unique case (idx)
        0: drive("bp0", 0, 10'd127, 64'h4000_0000_0000, 0,
                 32'h3F80_0000, 0);
        1: drive("bp1", 0, 10'd127, 64'h9000_0000_0000, 0,
                 32'h4010_0000, 0);
        2: drive("bp2", 0, 10'd127, 64'h4000_00C0_0000, 0,
                 32'h3F80_0002, 3'b001);
        default: drive("bp3", 1, 10'd127, 64'h4000_0060_0000, 0,
                       32'hBF80_0001, 3'b001);
      endcase
      step();
      if (acc) idx++;
    end
    #1;
    chk("bp_acc", idx, 2);
    chk("bp_ready", bus.in_ready, 0);
    chk("bp_valid", bus.out_valid, 1);
    held = bus.out_result;
    chk("bp_head", held, 32'h3F80_0000);
    step();
    chk("bp_stable", bus.out_result, held);

    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      unique case (idx)
        2: drive("bp2", 0, 10'd127, 64'h4000_00C0_0000, 0,
                 32'h3F80_0002, 3'b001);
        default: drive("bp3", 1, 10'd127, 64'h4000_0060_0000, 0,
                       32'hBF80_0001, 3'b001);
      endcase
      step();
      if (acc) idx++;
    end
    chk("bp_all_in", idx, 4);
    drain("drain_bp");

    bus.out_ready = 1'b0;
    drive("rs0", 0, 10'd127, 64'h4000_0000_0000, 0, 32'h3F80_0000, 0);
    step();
    step();
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_result", bus.out_result, 0);
    chk("rst_async_ready", bus.in_ready, 1);
    sbq.delete();
    tq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    chk("no_stale", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
